// File: rtl/multi_timer_pkg.sv
// Shared constants and types for the multi-channel tick timer bank.
// Optional irq support in the bank is enabled with the MULTI_TIMER_IRQ_EN macro.
package multi_timer_pkg;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int TICK_CYCLES_1MS   = 50000;

  typedef struct packed {
    logic en;
    logic periodic;
  } ctrl_t;

  // A single channel still needs a one-bit select so the bus port keeps its shape.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: count/reload/ctrl registers and a sticky expiry flag,
// advanced by the shared tick strobe.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               sel,
  input  logic               wr_count,
  input  logic               wr_ctrl,
  input  logic               clr_expired,
  input  logic [COUNT_W-1:0] wr_data,
  output logic [COUNT_W-1:0] count,
  output logic               expired
);

  logic [COUNT_W-1:0] count_r, count_s;
  logic [COUNT_W-1:0] reload_r, reload_s;
  ctrl_t              ctrl_r, ctrl_s;
  logic               expired_r, expired_s;
  logic               expire_s;

  // Next-state: a bus write to this channel takes priority over the tick.
  always_comb begin
    count_s  = count_r;
    reload_s = reload_r;
    ctrl_s   = ctrl_r;
    expire_s = 1'b0;
    if (sel && (wr_count || wr_ctrl)) begin
      if (wr_count) begin
        count_s  = wr_data;
        reload_s = wr_data;
      end else begin
        count_s  = count_r;
        reload_s = reload_r;
      end
      if (wr_ctrl) begin
        ctrl_s.en       = wr_data[CTRL_EN_BIT];
        ctrl_s.periodic = wr_data[CTRL_PERIODIC_BIT];
      end else begin
        ctrl_s = ctrl_r;
      end
    end else if (tick && ctrl_r.en) begin
      if (count_r > COUNT_W'(1)) begin
        count_s = count_r - COUNT_W'(1);
      end else begin
        expire_s = 1'b1;
        if (ctrl_r.periodic) begin
          count_s = reload_r;
        end else begin
          count_s   = {COUNT_W{1'b0}};
          ctrl_s.en = 1'b0;
        end
      end
    end else begin
      count_s = count_r;
    end
    // An expiry in the same cycle as a clear keeps the flag set.
    expired_s = expire_s ? 1'b1 : ((sel && clr_expired) ? 1'b0 : expired_r);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r   <= {COUNT_W{1'b0}};
      reload_r  <= {COUNT_W{1'b0}};
      ctrl_r    <= '{en: 1'b0, periodic: 1'b0};
      expired_r <= 1'b0;
    end else begin
      count_r   <= count_s;
      reload_r  <= reload_s;
      ctrl_r    <= ctrl_s;
      expired_r <= expired_s;
    end
  end

  assign count   = count_r;
  assign expired = expired_r;

endmodule

// File: rtl/multi_timer_bank.sv
// Bank of NUM_CH down-counting timers sharing one prescaler tick.
// Define MULTI_TIMER_IRQ_EN to add the irq mask register and irq output.
module multi_timer_bank
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int COUNT_W     = 8,
  parameter int TICK_CYCLES = TICK_CYCLES_1MS,
  parameter int TICK_W      = 16,
  localparam int CH_SEL_W   = sel_width(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CH_SEL_W-1:0] ch_sel,
  input  logic [COUNT_W-1:0]  wr_data,
  input  logic                wr_count,
  input  logic                wr_ctrl,
  input  logic                clr_expired,
  output logic [COUNT_W-1:0]  rd_count,
  output logic [NUM_CH-1:0]   expired,
`ifdef MULTI_TIMER_IRQ_EN
  input  logic                irq_mask_wr,
  input  logic [NUM_CH-1:0]   irq_mask_in,
  output logic                irq,
`endif
  output logic                tick
);

  logic [TICK_W-1:0]  presc_r;
  logic               tick_r;
  logic [COUNT_W-1:0] count_s [NUM_CH];

  // Free-running prescaler; tick is registered from the cycle before wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= TICK_W'(TICK_CYCLES - 1);
      tick_r  <= 1'b0;
    end else begin
      presc_r <= (presc_r == TICK_W'(0)) ? TICK_W'(TICK_CYCLES - 1) : (presc_r - TICK_W'(1));
      tick_r  <= (presc_r == TICK_W'(1));
    end
  end

  assign tick = tick_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel_s;
    assign sel_s = (ch_sel == CH_SEL_W'(i));

    multi_timer_channel #(.COUNT_W(COUNT_W)) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick_r),
      .sel         (sel_s),
      .wr_count    (wr_count),
      .wr_ctrl     (wr_ctrl),
      .clr_expired (clr_expired),
      .wr_data     (wr_data),
      .count       (count_s[i]),
      .expired     (expired[i])
    );
  end

  // Read mux; an unpopulated channel number reads as zero.
  always_comb begin
    rd_count = {COUNT_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      rd_count = (ch_sel == CH_SEL_W'(i)) ? count_s[i] : rd_count;
    end
  end

`ifdef MULTI_TIMER_IRQ_EN
  logic [NUM_CH-1:0] irq_mask_r;
  logic              irq_r;

  // Mask register and registered interrupt request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_r <= {NUM_CH{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      irq_mask_r <= irq_mask_wr ? irq_mask_in : irq_mask_r;
      irq_r      <= |(expired & irq_mask_r);
    end
  end

  assign irq = irq_r;
`endif

endmodule

// File: tb/tb_multi_timer_bank.sv
// Self-checking bench for multi_timer_bank with a 4-cycle tick and four channels.
module tb_multi_timer_bank;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       wc;
    logic       wctl;
    logic       clr;
    logic [7:0] rd;
    logic [3:0] e;
    logic       tk;
  } vec_t;

  typedef struct packed {
    logic [7:0] rd;
    logic [3:0] e;
    logic       tk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] ch_sel = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_count = 1'b0;
  logic       wr_ctrl = 1'b0;
  logic       clr_expired = 1'b0;
  logic [7:0] rd_count;
  logic [3:0] expired;
  logic       tick;
`ifdef MULTI_TIMER_IRQ_EN
  logic       irq_mask_wr = 1'b0;
  logic [3:0] irq_mask_in = 4'd0;
  logic       irq;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  multi_timer_bank #(
    .NUM_CH(4), .COUNT_W(8), .TICK_CYCLES(4), .TICK_W(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ch_sel      (ch_sel),
    .wr_data     (wr_data),
    .wr_count    (wr_count),
    .wr_ctrl     (wr_ctrl),
    .clr_expired (clr_expired),
    .rd_count    (rd_count),
    .expired     (expired),
`ifdef MULTI_TIMER_IRQ_EN
    .irq_mask_wr (irq_mask_wr),
    .irq_mask_in (irq_mask_in),
    .irq         (irq),
`endif
    .tick        (tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [7:0] d,
                       input logic wc, input logic wctl, input logic clr);
    ch_sel = s; wr_data = d; wr_count = wc; wr_ctrl = wctl; clr_expired = clr;
  endtask

  task automatic add(input logic [1:0] s, input logic [7:0] d, input logic wc,
                     input logic wctl, input logic clr, input logic [7:0] rd,
                     input logic [3:0] e, input logic tk);
    vec_t v;
    v.sel = s; v.data = d; v.wc = wc; v.wctl = wctl; v.clr = clr;
    v.rd = rd; v.e = e; v.tk = tk;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ticks;
    bit   found;
    exp_t x;

    // Vector k is consumed by posedge k+1; tick edges are posedges 4, 8, 12, ...
    add(2'd1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd3, 4'b0000, 1'b0);
    add(2'd1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd3, 4'b0000, 1'b0);
    add(2'd2, 8'd2, 1'b1, 1'b0, 1'b0, 8'd2, 4'b0000, 1'b1);
    add(2'd2, 8'd3, 1'b0, 1'b1, 1'b0, 8'd2, 4'b0000, 1'b0);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 4'b0000, 1'b0);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 4'b0000, 1'b0);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 4'b0000, 1'b1);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0000, 1'b0);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0000, 1'b0);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0000, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0000, 1'b1);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0110, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 4'b0010, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 4'b0010, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 4'b0010, 1'b1);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0010, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0010, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0010, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0010, 1'b1);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 4'b0110, 1'b0);
    add(2'd1, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 4'b0100, 1'b0);
    add(2'd2, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 4'b0000, 1'b0);
    add(2'd0, 8'd1, 1'b1, 1'b1, 1'b0, 8'd1, 4'b0000, 1'b1);
    add(2'd0, 8'd5, 1'b1, 1'b0, 1'b0, 8'd5, 4'b0000, 1'b0);

    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      ch_sel = 2'(s);
      #1;
      chk($sformatf("rst_rd_ch%0d", s), int'(rd_count), 0);
    end
    chk("rst_expired", int'(expired), 0);
    chk("rst_tick", int'(tick), 0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].sel, vecs[k].data, vecs[k].wc, vecs[k].wctl, vecs[k].clr);
      x.rd = vecs[k].rd; x.e = vecs[k].e; x.tk = vecs[k].tk;
      sb.push_back(x);
      @(negedge clk);
      x = sb.pop_front();
      chk($sformatf("vec%0d_rd", k), int'(rd_count), int'(x.rd));
      chk($sformatf("vec%0d_expired", k), int'(expired), int'(x.e));
      chk($sformatf("vec%0d_tick", k), int'(tick), int'(x.tk));
    end

    // ch0 was reloaded with 5 on a tick edge: expiry on the 5th following tick.
    drive(2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    ticks = 0; found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (expired[0]) begin found = 1'b1; break; end
      if (tick) ticks++;
    end
    chk("ch0_expired_seen", int'(found), 1);
    chk("ch0_ticks_to_expiry", ticks, 5);
    chk("ch0_oneshot_count", int'(rd_count), 0);

    // Loading 0 expires on the very next tick.
    drive(2'd1, 8'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'd1, 8'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'd1, 8'd0, 1'b0, 1'b0, 1'b0);
    ticks = 0; found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (expired[1]) begin found = 1'b1; break; end
      if (tick) ticks++;
    end
    chk("ch1_zero_expired_seen", int'(found), 1);
    chk("ch1_zero_ticks", ticks, 1);

    // ch3 counts from 10, then reset is pulled mid-count between edges.
    drive(2'd3, 8'd10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'd3, 8'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'd3, 8'd0, 1'b0, 1'b0, 1'b0);
    ticks = 0;
    for (int c = 0; c < 40 && ticks < 2; c++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    @(negedge clk);
    chk("ch3_count_before_reset", int'(rd_count), 8);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd", int'(rd_count), 0);
    chk("async_rst_expired", int'(expired), 0);
    chk("async_rst_tick", int'(tick), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int m = 1; m <= 84; m++) begin
      @(negedge clk);
      chk($sformatf("post_rst_tick_c%0d", m), int'(tick), (m % 4 == 3) ? 1 : 0);
      chk($sformatf("post_rst_expired_c%0d", m), int'(expired), 0);
    end
    chk("ch3_idle_after_reset", int'(rd_count), 0);

`ifdef MULTI_TIMER_IRQ_EN
    irq_mask_wr = 1'b1; irq_mask_in = 4'b0010;
    @(negedge clk);
    irq_mask_wr = 1'b0;
    drive(2'd1, 8'd1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'd2, 8'd1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'd2, 8'd0, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (expired[2:1] == 2'b11) begin found = 1'b1; break; end
    end
    chk("irq_both_expired", int'(found), 1);
    @(negedge clk);
    chk("irq_set", int'(irq), 1);
    drive(2'd1, 8'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(2'd1, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("irq_cleared", int'(irq), 0);
    chk("irq_ch2_still_expired", int'(expired[2]), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_timer_bank.md
Name: multi_timer_bank

Overview:
- Parametrised successor to the single-channel millisecond timer.
- One shared free-running prescaler generates a tick strobe; NUM_CH independent down-counters are clocked by that tick.
- Each channel supports one-shot or periodic (auto-reload) mode, has a sticky expired flag, and has a readable count.
- Sits on the processor peripheral bus; firmware polls the expired flags, or uses the optional irq.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- COUNT_W, 8, channel count/reload width in bits.
- TICK_CYCLES, 50000, clk cycles per tick (50000 = 1 ms at 50 MHz); must be >= 2.
- TICK_W, 16, prescaler width; must hold TICK_CYCLES-1.
- CH_SEL_W (localparam), $clog2(NUM_CH), with a minimum of 1.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- ch_sel, input, CH_SEL_W, channel addressed by the write/clear/read strobes.
- wr_data, input, COUNT_W, write data.
- wr_count, input, 1, load count and reload registers of ch_sel from wr_data.
- wr_ctrl, input, 1, write ctrl of ch_sel: wr_data[0] = enable, wr_data[1] = periodic.
- clr_expired, input, 1, clear the expired flag of ch_sel.
- rd_count, output, COUNT_W, combinational current count of ch_sel.
- expired, output, NUM_CH, sticky per-channel expiry flags.
- tick, output, 1, one-cycle prescaler strobe (for debug and other peripherals).

Behaviour:
- Reset: one clock and one async active-low reset (reset_n). Asserting reset_n low at any time, including mid-count, immediately clears:
  - prescaler to TICK_CYCLES-1
  - all count, reload, enable, periodic and expired bits to 0
  - tick to 0
- Prescaler:
  - Free-running from reset release; decrements every cycle.
  - At 0: tick is 1 for exactly that cycle, and the prescaler reloads TICK_CYCLES-1.
  - Tick period is exactly TICK_CYCLES cycles.
  - The first tick occurs TICK_CYCLES-1 cycles after reset release.
  - Not affected by any bus write.
- Channel update on a tick cycle, for each channel with enable=1:
  - count > 1: count <= count-1.
  - count <= 1: expire. expired <= 1. Then:
    - periodic=1: count <= reload, channel keeps running.
    - periodic=0: count <= 0, enable <= 0.
  - Net effect: loading N >= 1 expires on the N-th tick after the load. N = 0 expires on the next tick.
- Disabled channels hold their count; tick has no effect on them.
- wr_count writes count and reload together. It does not change enable.
- wr_ctrl writes enable and periodic. Clearing enable freezes count; re-enabling resumes from the frozen value.
- Simultaneous events, same channel, same cycle:
  - Write vs tick: the bus write (wr_count or wr_ctrl) wins; that channel ignores the tick.
  - wr_count and wr_ctrl both asserted: both take effect.
  - clr_expired vs expiry: expiry wins; the flag stays 1.
- Strobes address only ch_sel; all other channels update normally on the tick.
- ch_sel >= NUM_CH: writes and clears are ignored; rd_count reads 0.
- expired is a registered output. It rises the cycle after the expiring tick and stays high until clr_expired or reset.
- All arithmetic is unsigned COUNT_W. Count never wraps below 0.

Optional Feature:
- Macro: MULTI_TIMER_IRQ_EN.
- When defined:
  - Adds a per-channel irq_mask register, written by the input irq_mask_wr (1 bit) together with the input irq_mask_in (NUM_CH bits). Reset value 0.
  - Adds output irq (1 bit), registered: irq = |(expired & irq_mask), updated the cycle after expired changes.
- When undefined: none of those ports or registers exist; flags are polled only.

Decomposition:
- Package multi_timer_pkg holds:
  - ctrl bit indices: CTRL_EN_BIT = 0, CTRL_PERIODIC_BIT = 1
  - default TICK_CYCLES_1MS = 50000
- Sub-module multi_timer_channel (one count, reload and ctrl slice; inputs tick, write/clear strobes and data; outputs count and expired), instantiated NUM_CH times with a generate loop. The prescaler and read mux live in the top.

Test Plan (TICK_CYCLES=4, NUM_CH=4, COUNT_W=8):
- Reset release -> tick pulses at cycles 3, 7, 11 after release; all expired = 0, rd_count = 0.
- ch1: wr_count 3, wr_ctrl 0b01 (one-shot) -> expired[1] set after the 3rd tick; enable drops; rd_count = 0; further ticks leave it unchanged; clr_expired clears it.
- ch2: wr_count 2, wr_ctrl 0b11 (periodic) -> expired[2] sets after ticks 2, 4, 6; count sequence 2, 1, 2, 1; between expiries, clr_expired brings the flag back to 0.
- wr_count 5 on ch0 in the same cycle as tick -> count = 5 (tick ignored); expiry 5 ticks later. clr_expired coincident with the expiring tick -> expired stays 1.
- Enable ch3 with count 10, assert reset_n low mid-count asynchronously (between clock edges) -> all state is 0 immediately; after release, ch3 stays idle through 20 ticks.
- MULTI_TIMER_IRQ_EN: mask 0b0010, ch1 and ch2 expire -> irq = 1; clr ch1 -> irq = 0 while expired[2] is still 1.
